// File: rtl/mips_if_id_ex_pkg.sv
// Shared encodings for the IF/ID/EX front datapath: opcode and funct values,
// the ALU operation set, branch kinds and the decoded control word.
package mips_if_id_ex_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [4:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI,
    ALU_MFHI, ALU_MFLO, ALU_LINK, ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU
  } alu_op_e;

  typedef enum logic [2:0] {BR_NONE, BR_BEQ, BR_BNE, BR_J, BR_JR} br_e;

  typedef struct packed {
    alu_op_e    op;
    br_e        br;
    logic       use_imm;
    logic       zero_ext;
    logic       shift_var;
    logic       wr_en;
    logic [4:0] wr_reg;
  } ctrl_t;

  // Full instruction decode; anything unrecognised becomes a no-op.
  function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] funct,
                                   input logic [4:0] rt, input logic [4:0] rd);
    ctrl_t c;
    c.op        = ALU_NONE;
    c.br        = BR_NONE;
    c.use_imm   = 1'b0;
    c.zero_ext  = 1'b0;
    c.shift_var = 1'b0;
    c.wr_en     = 1'b0;
    c.wr_reg    = '0;
    case (op)
      OP_RTYPE: begin
        c.wr_en  = 1'b1;
        c.wr_reg = rd;
        case (funct)
          FN_ADD, FN_ADDU: c.op = ALU_ADD;
          FN_SUB, FN_SUBU: c.op = ALU_SUB;
          FN_AND:  c.op = ALU_AND;
          FN_OR:   c.op = ALU_OR;
          FN_XOR:  c.op = ALU_XOR;
          FN_NOR:  c.op = ALU_NOR;
          FN_SLT:  c.op = ALU_SLT;
          FN_SLTU: c.op = ALU_SLTU;
          FN_SLL:  c.op = ALU_SLL;
          FN_SRL:  c.op = ALU_SRL;
          FN_SRA:  c.op = ALU_SRA;
          FN_SLLV: begin c.op = ALU_SLL; c.shift_var = 1'b1; end
          FN_SRLV: begin c.op = ALU_SRL; c.shift_var = 1'b1; end
          FN_SRAV: begin c.op = ALU_SRA; c.shift_var = 1'b1; end
          FN_MFHI: c.op = ALU_MFHI;
          FN_MFLO: c.op = ALU_MFLO;
          FN_JR:    begin c.br = BR_JR;      c.wr_en = 1'b0; end
          FN_MULT:  begin c.op = ALU_MULT;  c.wr_en = 1'b0; end
          FN_MULTU: begin c.op = ALU_MULTU; c.wr_en = 1'b0; end
          FN_DIV:   begin c.op = ALU_DIV;   c.wr_en = 1'b0; end
          FN_DIVU:  begin c.op = ALU_DIVU;  c.wr_en = 1'b0; end
          default:  c.wr_en = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin c.op = ALU_ADD;  c.use_imm = 1'b1; c.wr_en = 1'b1; c.wr_reg = rt; end
      OP_SLTI:  begin c.op = ALU_SLT;  c.use_imm = 1'b1; c.wr_en = 1'b1; c.wr_reg = rt; end
      OP_SLTIU: begin c.op = ALU_SLTU; c.use_imm = 1'b1; c.wr_en = 1'b1; c.wr_reg = rt; end
      OP_ANDI:  begin c.op = ALU_AND;  c.use_imm = 1'b1; c.zero_ext = 1'b1; c.wr_en = 1'b1; c.wr_reg = rt; end
      OP_ORI:   begin c.op = ALU_OR;   c.use_imm = 1'b1; c.zero_ext = 1'b1; c.wr_en = 1'b1; c.wr_reg = rt; end
      OP_XORI:  begin c.op = ALU_XOR;  c.use_imm = 1'b1; c.zero_ext = 1'b1; c.wr_en = 1'b1; c.wr_reg = rt; end
      OP_LUI:   begin c.op = ALU_LUI;  c.wr_en = 1'b1; c.wr_reg = rt; end
      OP_BEQ:   c.br = BR_BEQ;
      OP_BNE:   c.br = BR_BNE;
      OP_J:     c.br = BR_J;
      OP_JAL:   begin c.br = BR_J; c.op = ALU_LINK; c.wr_en = 1'b1; c.wr_reg = REG_RA; end
      default:  c.op = ALU_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_if_id_ex_if.sv
// Bus bundle between the surrounding core (master) and the datapath (slave).
interface mips_if_id_ex_if;
  logic [31:0] newPC;
  logic [31:0] W_Ins;
  logic        WE;
  logic [31:0] PC;
  logic [31:0] nextPC;
  logic [31:0] Ins;
  logic [31:0] Rdata1;
  logic [31:0] Rdata2;
  logic [31:0] Ed32;
  logic [31:0] Result;
  logic [31:0] newPC_EX;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output newPC, W_Ins, WE,
    input  PC, nextPC, Ins, Rdata1, Rdata2, Ed32, Result, newPC_EX, HI, LO
  );

  modport slave (
    input  newPC, W_Ins, WE,
    output PC, nextPC, Ins, Rdata1, Rdata2, Ed32, Result, newPC_EX, HI, LO
  );
endinterface

// File: rtl/mips_if_id_ex_ex_stage.sv
// Execute: ALU, HI/LO multiply/divide registers and next-PC selection.
module mips_if_id_ex_ex_stage
  import mips_if_id_ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  alu_op_e     alu_op,
  input  br_e         br,
  input  logic        use_imm,
  input  logic        shift_var,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  input  logic [31:0] ed32,
  input  logic [4:0]  shamt,
  input  logic [25:0] target,
  input  logic [31:0] next_pc,
  output logic [31:0] result,
  output logic [31:0] new_pc_ex,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  logic [31:0] b;
  logic [4:0]  sh;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] q_s, r_s, q_u, r_u;
  logic        div_zero;

  assign b        = use_imm ? ed32 : rdata2;
  assign sh       = shift_var ? rdata1[4:0] : shamt;
  assign prod_s   = {{32{rdata1[31]}}, rdata1} * {{32{rdata2[31]}}, rdata2};
  assign prod_u   = {32'h0, rdata1} * {32'h0, rdata2};
  assign div_zero = (rdata2 == '0);

  // Divider outputs are forced to zero when the divisor is zero so no X leaks.
  always_comb begin
    q_s = '0;
    r_s = '0;
    q_u = '0;
    r_u = '0;
    if (!div_zero) begin
      q_s = $signed(rdata1) / $signed(rdata2);
      r_s = $signed(rdata1) % $signed(rdata2);
      q_u = rdata1 / rdata2;
      r_u = rdata1 % rdata2;
    end
  end

  // ALU result; ops without a value yield zero.
  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:  result = rdata1 + b;
      ALU_SUB:  result = rdata1 - b;
      ALU_AND:  result = rdata1 & b;
      ALU_OR:   result = rdata1 | b;
      ALU_XOR:  result = rdata1 ^ b;
      ALU_NOR:  result = ~(rdata1 | b);
      ALU_SLT:  result = {31'h0, $signed(rdata1) < $signed(b)};
      ALU_SLTU: result = {31'h0, rdata1 < b};
      ALU_SLL:  result = rdata2 << sh;
      ALU_SRL:  result = rdata2 >> sh;
      ALU_SRA:  result = $signed(rdata2) >>> sh;
      ALU_LUI:  result = {ed32[15:0], 16'h0000};
      ALU_MFHI: result = hi;
      ALU_MFLO: result = lo;
      ALU_LINK: result = next_pc;
      default:  result = '0;
    endcase
  end

  // Next-PC selection: sequential, taken branch, jump or register jump.
  always_comb begin
    new_pc_ex = next_pc;
    case (br)
      BR_BEQ: if (rdata1 == rdata2) new_pc_ex = next_pc + {ed32[29:0], 2'b00};
      BR_BNE: if (rdata1 != rdata2) new_pc_ex = next_pc + {ed32[29:0], 2'b00};
      BR_J:   new_pc_ex = {next_pc[31:28], target, 2'b00};
      BR_JR:  new_pc_ex = rdata1;
      default: new_pc_ex = next_pc;
    endcase
  end

  // HI/LO update for multiply/divide; divide by zero leaves them untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else begin
      case (alu_op)
        ALU_MULT:  {hi, lo} <= prod_s;
        ALU_MULTU: {hi, lo} <= prod_u;
        ALU_DIV:   if (!div_zero) begin lo <= q_s; hi <= r_s; end
        ALU_DIVU:  if (!div_zero) begin lo <= q_u; hi <= r_u; end
        default:   ;
      endcase
    end
  end
endmodule

// File: rtl/mips_if_id_ex_id_stage.sv
// Decode: control decode, immediate extension and the 32x32 register file.
module mips_if_id_ex_id_stage
  import mips_if_id_ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins,
  input  logic [31:0] result,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic [31:0] ed32,
  output alu_op_e     alu_op,
  output br_e         br,
  output logic        use_imm,
  output logic        shift_var
);
  logic [31:0] gpr [32];
  ctrl_t       ctrl;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        unused_shamt;

  assign rs           = ins[25:21];
  assign rt           = ins[20:16];
  assign unused_shamt = ^ins[10:6];
  assign ctrl         = decode(ins[31:26], ins[5:0], rt, ins[15:11]);

  assign alu_op    = ctrl.op;
  assign br        = ctrl.br;
  assign use_imm   = ctrl.use_imm;
  assign shift_var = ctrl.shift_var;

  assign ed32 = ctrl.zero_ext ? {16'h0000, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};

  assign rdata1 = (rs == '0) ? '0 : gpr[rs];
  assign rdata2 = (rt == '0) ? '0 : gpr[rt];

  // Write-back of the EX result; $0 writes are discarded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 32; i++) gpr[i] <= '0;
    end else if (ctrl.wr_en && ctrl.wr_reg != '0) begin
      gpr[ctrl.wr_reg] <= result;
    end
  end
endmodule

// File: rtl/mips_if_id_ex_if_stage.sv
// Fetch: PC register plus writable instruction memory with combinational read.
module mips_if_id_ex_if_stage #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] new_pc,
  input  logic [31:0] w_ins,
  input  logic        we,
  output logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic [31:0] ins
);
  localparam int unsigned AW = $clog2(IMEM_WORDS);

  logic [31:0] imem [IMEM_WORDS];
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{new_pc[31:AW+2], new_pc[1:0]};

  // PC follows newPC every edge outside reset.
  always_ff @(posedge clk) begin
    if (!rst) pc <= RESET_PC;
    else      pc <= new_pc;
  end

  // Memory writes are not gated by reset so it can be preloaded while held.
  always_ff @(posedge clk) begin
    if (we) imem[new_pc[AW+1:2]] <= w_ins;
  end

  assign ins     = imem[pc[AW+1:2]];
  assign next_pc = pc + 32'd4;
endmodule

// File: rtl/mips_if_id_ex.sv
// Single-clock MIPS fetch/decode/execute datapath; the PC loop is closed outside.
module mips_if_id_ex
  import mips_if_id_ex_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RST,
  mips_if_id_ex_if.slave    bus
);
  logic [31:0] pc, next_pc, ins;
  logic [31:0] rdata1, rdata2, ed32, result, new_pc_ex, hi, lo;
  alu_op_e     alu_op;
  br_e         br;
  logic        use_imm, shift_var;

  mips_if_id_ex_if_stage #(.IMEM_WORDS(IMEM_WORDS), .RESET_PC(RESET_PC)) u_if (
    .clk(CLK), .rst(RST), .new_pc(bus.newPC), .w_ins(bus.W_Ins), .we(bus.WE),
    .pc(pc), .next_pc(next_pc), .ins(ins)
  );

  mips_if_id_ex_id_stage u_id (
    .clk(CLK), .rst(RST), .ins(ins), .result(result),
    .rdata1(rdata1), .rdata2(rdata2), .ed32(ed32),
    .alu_op(alu_op), .br(br), .use_imm(use_imm), .shift_var(shift_var)
  );

  mips_if_id_ex_ex_stage u_ex (
    .clk(CLK), .rst(RST), .alu_op(alu_op), .br(br), .use_imm(use_imm),
    .shift_var(shift_var), .rdata1(rdata1), .rdata2(rdata2), .ed32(ed32),
    .shamt(ins[10:6]), .target(ins[25:0]), .next_pc(next_pc),
    .result(result), .new_pc_ex(new_pc_ex), .hi(hi), .lo(lo)
  );

  assign bus.PC       = pc;
  assign bus.nextPC   = next_pc;
  assign bus.Ins      = ins;
  assign bus.Rdata1   = rdata1;
  assign bus.Rdata2   = rdata2;
  assign bus.Ed32     = ed32;
  assign bus.Result   = result;
  assign bus.newPC_EX = new_pc_ex;
  assign bus.HI       = hi;
  assign bus.LO       = lo;
endmodule

// File: tb/tb_mips_if_id_ex.sv
// Bench for mips_if_id_ex: preloads a program during reset, walks a vector
// table through a scoreboard queue, then runs HI/LO and fetch corner cases.
module tb_mips_if_id_ex;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mips_if_id_ex_if bus();

  mips_if_id_ex #(.IMEM_WORDS(256), .RESET_PC(32'h0000_0000)) dut (
    .CLK(clk), .RST(rst), .bus(bus)
  );

  typedef struct {
    logic [31:0] pc, ins, rd1, rd2, ed32, result, npc;
  } vec_t;

  typedef struct {
    logic [31:0] addr, word;
  } load_t;

  vec_t  vecs [19];
  vec_t  sb [$];
  load_t loads [$];
  int    errors = 0;
  int    checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_load(input logic [31:0] addr, input logic [31:0] word);
    load_t l;
    l.addr = addr;
    l.word = word;
    loads.push_back(l);
  endtask

  task automatic step(input logic [31:0] pc);
    bus.newPC = pc;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    vec_t e;
    //          pc        ins           rd1           rd2           ed32          result        npc
    vecs[0]  = '{32'h00, 32'h20010005, 32'h0,        32'h0,        32'h5,        32'h5,        32'h04};
    vecs[1]  = '{32'h04, 32'h20020007, 32'h0,        32'h0,        32'h7,        32'h7,        32'h08};
    vecs[2]  = '{32'h08, 32'h00221820, 32'h5,        32'h7,        32'h1820,     32'hC,        32'h0C};
    vecs[3]  = '{32'h0C, 32'h2001FFFF, 32'h0,        32'h5,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'h10};
    vecs[4]  = '{32'h10, 32'h10000003, 32'h0,        32'h0,        32'h3,        32'h0,        32'h20};
    vecs[5]  = '{32'h20, 32'h3404FFFF, 32'h0,        32'h0,        32'h0000FFFF, 32'h0000FFFF, 32'h24};
    vecs[6]  = '{32'h24, 32'h14000003, 32'h0,        32'h0,        32'h3,        32'h0,        32'h28};
    vecs[7]  = '{32'h28, 32'h00622822, 32'hC,        32'h7,        32'h2822,     32'h5,        32'h2C};
    vecs[8]  = '{32'h2C, 32'h0020302A, 32'hFFFFFFFF, 32'h0,        32'h302A,     32'h1,        32'h30};
    vecs[9]  = '{32'h30, 32'h0020382B, 32'hFFFFFFFF, 32'h0,        32'h382B,     32'h0,        32'h34};
    vecs[10] = '{32'h34, 32'h3C098000, 32'h0,        32'h0,        32'hFFFF8000, 32'h80000000, 32'h38};
    vecs[11] = '{32'h38, 32'h00094103, 32'h0,        32'h80000000, 32'h4103,     32'hF8000000, 32'h3C};
    vecs[12] = '{32'h3C, 32'h08000012, 32'h0,        32'h0,        32'h12,       32'h0,        32'h48};
    vecs[13] = '{32'h48, 32'h0C000020, 32'h0,        32'h0,        32'h20,       32'h4C,       32'h80};
    vecs[14] = '{32'h80, 32'h03E00008, 32'h4C,       32'h0,        32'h8,        32'h0,        32'h4C};
    vecs[15] = '{32'h4C, 32'h00495007, 32'h7,        32'h80000000, 32'h5007,     32'hFF000000, 32'h50};
    vecs[16] = '{32'h50, 32'h00805827, 32'h0000FFFF, 32'h0,        32'h5827,     32'hFFFF0000, 32'h54};
    vecs[17] = '{32'h54, 32'h302C8F0F, 32'hFFFFFFFF, 32'h0,        32'h00008F0F, 32'h00008F0F, 32'h58};
    vecs[18] = '{32'h58, 32'h1420FFFF, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 32'h0,        32'h58};

    for (int i = 0; i < 19; i++) add_load(vecs[i].pc, vecs[i].ins);
    add_load(32'h100, 32'h20010006);  // addi $1,$0,6
    add_load(32'h104, 32'h20020007);  // addi $2,$0,7
    add_load(32'h108, 32'h00220018);  // mult $1,$2
    add_load(32'h10C, 32'h00002812);  // mflo $5
    add_load(32'h110, 32'h0022001A);  // div $1,$2
    add_load(32'h114, 32'h0020001A);  // div $1,$0
    add_load(32'h118, 32'h20000009);  // addi $0,$0,9
    add_load(32'h11C, 32'h00003020);  // add $6,$0,$0
    add_load(32'h120, 32'h2003FFFE);  // addi $3,$0,-2
    add_load(32'h124, 32'h00620018);  // mult $3,$2
    add_load(32'h128, 32'h00620019);  // multu $3,$2
    add_load(32'h12C, 32'h0062001B);  // divu $3,$2
    add_load(32'h130, 32'h0062001A);  // div $3,$2
    add_load(32'h134, 32'h00003810);  // mfhi $7
    add_load(32'h3FC, 32'h08000010);  // j 0x40 (aliased by PC 0xFFFFFFFC)

    // Reset state with an add word at PC 0.
    rst       = 1'b0;
    bus.WE    = 1'b1;
    bus.newPC = 32'h0;
    bus.W_Ins = 32'h00221820;
    tick();
    check("reset_pc", bus.PC, 32'h0);
    check("reset_hi", bus.HI, 32'h0);
    check("reset_lo", bus.LO, 32'h0);
    check("reset_rdata1", bus.Rdata1, 32'h0);
    check("reset_rdata2", bus.Rdata2, 32'h0);
    check("reset_ins", bus.Ins, 32'h00221820);
    check("reset_result", bus.Result, 32'h0);

    // Preload the program while reset is held.
    foreach (loads[i]) begin
      bus.newPC = loads[i].addr;
      bus.W_Ins = loads[i].word;
      tick();
    end
    check("preload_pc", bus.PC, 32'h0);
    bus.WE    = 1'b0;
    bus.newPC = 32'h0;
    rst       = 1'b1;

    // Table walk: the row at the current PC is checked before the edge executes it.
    sb.push_back(vecs[0]);
    for (int i = 0; i < 19; i++) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1 at row %0d", i);
      end else begin
        e = sb.pop_front();
        check($sformatf("v%0d_pc", i), bus.PC, e.pc);
        check($sformatf("v%0d_ins", i), bus.Ins, e.ins);
        check($sformatf("v%0d_rdata1", i), bus.Rdata1, e.rd1);
        check($sformatf("v%0d_rdata2", i), bus.Rdata2, e.rd2);
        check($sformatf("v%0d_ed32", i), bus.Ed32, e.ed32);
        check($sformatf("v%0d_result", i), bus.Result, e.result);
        check($sformatf("v%0d_newpc_ex", i), bus.newPC_EX, e.npc);
        check($sformatf("v%0d_nextpc", i), bus.nextPC, e.pc + 32'd4);
      end
      if (i < 18) begin
        bus.newPC = vecs[i+1].pc;
        sb.push_back(vecs[i+1]);
        tick();
      end
    end

    // HI/LO sequence.
    step(32'h100); check("addi6_result", bus.Result, 32'h6);
    step(32'h104); check("addi7_result", bus.Result, 32'h7);
    step(32'h108); check("mult_result", bus.Result, 32'h0);
    step(32'h10C);
    check("mult_hi", bus.HI, 32'h0);
    check("mult_lo", bus.LO, 32'd42);
    check("mflo_result", bus.Result, 32'd42);
    step(32'h110);
    step(32'h114);
    check("div_hi", bus.HI, 32'h6);
    check("div_lo", bus.LO, 32'h0);
    step(32'h118);
    check("div0_hi", bus.HI, 32'h6);
    check("div0_lo", bus.LO, 32'h0);
    check("addi_r0_result", bus.Result, 32'h9);
    step(32'h11C);
    check("r0_rdata1", bus.Rdata1, 32'h0);
    check("r0_rdata2", bus.Rdata2, 32'h0);
    step(32'h120);
    step(32'h124);
    check("neg_rdata1", bus.Rdata1, 32'hFFFFFFFE);
    step(32'h128);
    check("mults_hi", bus.HI, 32'hFFFFFFFF);
    check("mults_lo", bus.LO, 32'hFFFFFFF2);
    step(32'h12C);
    check("multu_hi", bus.HI, 32'h6);
    check("multu_lo", bus.LO, 32'hFFFFFFF2);
    step(32'h130);
    check("divu_hi", bus.HI, 32'h2);
    check("divu_lo", bus.LO, 32'h24924924);
    step(32'h134);
    check("divs_hi", bus.HI, 32'hFFFFFFFE);
    check("divs_lo", bus.LO, 32'h0);
    check("mfhi_result", bus.Result, 32'hFFFFFFFE);

    // Write to the word being fetched: old word until the edge.
    bus.WE    = 1'b1;
    bus.newPC = 32'h134;
    bus.W_Ins = 32'h2008ABCD;
    #1;
    check("wr_fetch_old", bus.Ins, 32'h00003810);
    tick();
    bus.WE = 1'b0;
    check("wr_fetch_new", bus.Ins, 32'h2008ABCD);
    check("wr_fetch_ed32", bus.Ed32, 32'hFFFFABCD);
    check("wr_fetch_result", bus.Result, 32'hFFFFABCD);

    // PC wraparound: nextPC rolls to 0, jump region comes from nextPC.
    step(32'hFFFFFFFC);
    check("wrap_pc", bus.PC, 32'hFFFFFFFC);
    check("wrap_ins", bus.Ins, 32'h08000010);
    check("wrap_nextpc", bus.nextPC, 32'h0);
    check("wrap_newpc_ex", bus.newPC_EX, 32'h40);

    // Mid-run reset clears PC, HI/LO and GPRs.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rerst_pc", bus.PC, 32'h0);
    check("rerst_hi", bus.HI, 32'h0);
    check("rerst_lo", bus.LO, 32'h0);
    check("rerst_gpr1", bus.Rdata2, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mips_if_id_ex.md
Name: mips_if_id_ex

Overview:
- Single-clock MIPS front datapath: instruction fetch (PC register + writable instruction memory), decode (register file read, immediate extension), and execute (ALU, HI/LO, next-PC computation).
- The EX result is written back to the register file in the same cycle; there is no memory stage.
- The next PC is an input; the computed target is exported, so the surrounding core or bench closes the PC loop.
- Internally it is three stages, named in the Decomposition section, wired combinationally inside one clock.

Parameters:
- IMEM_WORDS, 256, instruction memory depth in 32-bit words; address = PC[log2(IMEM_WORDS)+1:2].
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  synchronous active-low reset.
- newPC  in  32  PC loaded on every clock edge; also the instruction-memory write address.
- W_Ins  in  32  instruction word to write.
- WE  in  1  instruction-memory write enable.
- PC  out  32  current PC register.
- nextPC  out  32  PC+4.
- Ins  out  32  instruction at PC (combinational read).
- Rdata1  out  32  GPR[rs].
- Rdata2  out  32  GPR[rt].
- Ed32  out  32  extended 16-bit immediate.
- Result  out  32  EX result, also the register-file write data.
- newPC_EX  out  32  computed next PC (branch/jump aware).
- HI  out  32  HI register.
- LO  out  32  LO register.

Behaviour:
Reset (RST==0 at posedge):
- PC=RESET_PC.
- All 32 GPRs = 0.
- HI=LO=0.
- Instruction memory is not cleared. WE writes are honoured during reset, so memory can be preloaded.

Fetch (IF):
- Each posedge out of reset: PC <= newPC.
- If WE: imem[newPC word index] <= W_Ins on the same edge.
- Ins = imem[PC word index], combinational.
- nextPC = PC+4, modulo 2^32.

Decode (ID):
- Rdata1/Rdata2 are read combinationally. Reads are not bypassed: a same-cycle write is visible next cycle.
- Ed32 is zero-extended for andi/ori/xori and sign-extended otherwise.
- Write destination:
  - R-type: rd.
  - I-type ALU ops and lui: rt.
  - jal: 31.
- No write for beq, bne, j, jr, mult(u), div(u), or unrecognised opcodes.
- Writes go to the destination on posedge with data = Result.
- GPR0 always reads 0; writes to it are dropped.

Execute (EX), 32-bit wraparound arithmetic, no overflow traps:
- R-type: add, addu, sub, subu, and, or, xor, nor, slt (signed), sltu, sll, srl, sra (shamt), sllv, srlv, srav (Rdata1[4:0]), mfhi, mflo, jr.
- I-type: addi, addiu, slti, sltiu, andi, ori, xori, lui (Result = imm<<16), beq, bne.
- J-type: j, jal (Result = nextPC).
- mult/multu: {HI,LO} <= 64-bit product on posedge.
- div/divu: LO <= quotient, HI <= remainder. Divide by zero leaves HI/LO unchanged.
- Result = 0 for ops that produce no value.
- newPC_EX:
  - nextPC by default.
  - beq/bne taken: nextPC + (Ed32<<2).
  - j/jal: {nextPC[31:28], target, 2'b00}.
  - jr: Rdata1.
- Latency: all outputs except PC, HI, LO and GPR contents are combinational functions of the current PC and state within one cycle.
- Simultaneous WE write and fetch of the same address: Ins shows the old word until the edge.

Decomposition:
- Shared package holds:
  - opcode constants;
  - funct constants;
  - the ALU-op enum;
  - the register-index constant for $31.
- Natural sub-modules: if_stage, id_stage (containing the register file), and ex_stage, instantiated in mips_if_id_ex.

Test Plan:
1. Reset low for 1 edge with newPC=0 -> PC=0, HI=LO=0, Rdata1=Rdata2=0, Result=0 for an ADD word.
2. WE=1, newPC=0, W_Ins=0x20010005 (addi $1,$0,5), then WE=0:
   - Ins=0x20010005, Ed32=5, Result=5, newPC_EX=4.
   - Next cycle Rdata1 for rs=1 reads 5.
3. Preload the sequence addi $1,$0,5 / addi $2,$0,7 / add $3,$1,$2 (0x00221820), driving newPC from newPC_EX -> Result=12 at PC=8, and GPR3=12.
4. addi $1,$0,-1 (0x2001FFFF) -> Ed32=0xFFFFFFFF, Result=0xFFFFFFFF. Then ori $4,$0,0xFFFF -> Ed32=0x0000FFFF.
5. beq $0,$0,+3 at PC=0x10 -> newPC_EX=0x20. bne $0,$0,+3 -> newPC_EX=0x14. j 0x40 -> newPC_EX=0x100. jal -> GPR31=nextPC.
6. With GPR1=6 and GPR2=7:
   - mult $1,$2 -> HI=0, LO=42. mflo $5 -> Result=42.
   - div $1,$2 -> LO=0, HI=6.
   - div by GPR0 -> HI/LO unchanged.
   - Write to $0 -> $0 still reads 0.
